// File: rtl/cv32e40p_aligner_feeder.sv
// Parity-protected circular instruction buffer between instruction memory and the aligner.
// The head word is visible combinationally; there is no input-to-output bypass.
module cv32e40p_aligner_feeder #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid_i,
    input  logic [31:0]              in_rdata_i,
    output logic                     in_ready_o,
    input  logic                     parity_inject_i,
    input  logic                     flush_i,
    output logic                     fetch_valid_o,
    output logic [31:0]              fetch_rdata_o,
    input  logic                     aligner_ready_i,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     perr_o,
    output logic [7:0]               perr_cnt_o,
    input  logic                     perr_clr_i
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("cv32e40p_aligner_feeder: DEPTH must be a power of two >= 2");
    end

    typedef struct packed {
        logic        parity;
        logic [31:0] data;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr;
    logic [PW:0]   level;
    logic          push;
    logic          pop;

    assign head          = mem[rptr];
    assign in_ready_o    = (level != FULL);
    assign fetch_valid_o = (level != '0);
    assign fetch_rdata_o = fetch_valid_o ? head.data : 32'h0;
    assign perr_o        = fetch_valid_o && ((^head.data) != head.parity);
    assign level_o       = level;

    assign push = in_valid_i && in_ready_o && !flush_i;
    assign pop  = fetch_valid_o && aligner_ready_i && !flush_i;

    // NOTE: storage has no reset; the level counter alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= '{parity: (^in_rdata_i) ^ parity_inject_i, data: in_rdata_i};
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr  <= '0;
            wptr  <= '0;
            level <= '0;
        end else if (flush_i) begin
            rptr  <= '0;
            wptr  <= '0;
            level <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            case ({push, pop})
                2'b10:   level <= level + (PW+1)'(1);
                2'b01:   level <= level - (PW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    // Clear wins over a same-cycle increment; a flush never pops, so it leaves the count alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_cnt_o <= 8'h00;
        end else if (perr_clr_i) begin
            perr_cnt_o <= 8'h00;
        end else if (pop && perr_o && perr_cnt_o != 8'hFF) begin
            perr_cnt_o <= perr_cnt_o + 8'h01;
        end
    end

endmodule

// File: doc/cv32e40p_aligner_feeder.md
CV32E40P_ALIGNER_FEEDER -- requirements
Module: cv32e40p_aligner_feeder

Interface
REQ-001 Parameter DEPTH, default 4, number of 32-bit instruction-word entries; the block SHALL support only powers of two that are at least 2.
REQ-002 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 in_valid_i  input  1  fetched word from instruction memory is valid.
REQ-005 in_rdata_i  input  32  fetched word.
REQ-006 in_ready_o  output  1  feeder can accept a word; equals not-full.
REQ-007 parity_inject_i  input  1  when a word is pushed, its stored parity bit SHALL be inverted (fault injection).
REQ-008 flush_i  input  1  branch/hwloop redirect; discards all buffered words.
REQ-009 fetch_valid_o  output  1  head word is valid toward the aligner.
REQ-010 fetch_rdata_o  output  32  head word toward the aligner.
REQ-011 aligner_ready_i  input  1  aligner accepts the head word.
REQ-012 level_o  output  $clog2(DEPTH)+1  number of occupied entries.
REQ-013 perr_o  output  1  head word fails its parity check (combinational).
REQ-014 perr_cnt_o  output  8  saturating count of popped words that failed parity.
REQ-015 perr_clr_i  input  1  clears perr_cnt_o.

Function
REQ-016 Storage SHALL be a circular buffer of DEPTH entries, each holding 32 data bits plus 1 even-parity bit, with read and write pointers that wrap from DEPTH-1 to 0.
REQ-017 Push SHALL occur when in_valid_i && in_ready_o && !flush_i; the stored parity is ^in_rdata_i XOR parity_inject_i.
REQ-018 Pop SHALL occur when fetch_valid_o && aligner_ready_i && !flush_i.
REQ-019 fetch_valid_o SHALL equal (level_o != 0), and fetch_rdata_o SHALL be the entry at the read pointer; there is no input-to-output bypass, so push-to-visible latency is 1 cycle.
REQ-020 When fetch_valid_o is 0, fetch_rdata_o SHALL be 32'h0.
REQ-021 Simultaneous push and pop with 0 < level < DEPTH SHALL leave level_o unchanged and advance both pointers.
REQ-022 When full (level_o == DEPTH), in_ready_o SHALL be 0; a same-cycle pop does not re-enable in_ready_o until the next cycle.
REQ-023 When empty, a pop SHALL be impossible; aligner_ready_i SHALL be ignored.
REQ-024 flush_i SHALL have priority over push and pop: on the next edge level_o becomes 0 and both pointers become 0; any same-cycle push is dropped, and perr_cnt_o does not change.
REQ-025 perr_o SHALL equal fetch_valid_o && (^head_data != head_parity).
REQ-026 perr_cnt_o SHALL increment by 1 on each pop with perr_o = 1 and saturate at 8'hFF.
REQ-027 perr_clr_i SHALL zero perr_cnt_o on the next edge and takes priority over a same-cycle increment.
REQ-028 Data written into an entry SHALL not change until that entry is popped or flushed.

Reset
REQ-029 When rst_n = 0, pointers, level_o and perr_cnt_o SHALL be 0 immediately, regardless of clk.
REQ-030 While in reset, the outputs SHALL be: fetch_valid_o = 0, fetch_rdata_o = 0, perr_o = 0, in_ready_o = 1.
REQ-031 Entry storage SHALL not need to be reset.
REQ-032 Deasserting rst_n SHALL take effect on the next clk edge; the first push is possible in the first cycle after deassertion.
REQ-033 Asserting rst_n mid-operation SHALL discard all entries, exactly as a flush, and SHALL also clear perr_cnt_o.

Verification
REQ-034 Push 32'h0000_0013 with aligner_ready_i = 0 -> the next cycle fetch_valid_o = 1, fetch_rdata_o = 32'h0000_0013, level_o = 1, perr_o = 0.
REQ-035 Push 4 words A0..A3 back-to-back with aligner_ready_i = 0 -> level_o = 4 and in_ready_o = 0; a 5th word offered is not stored; then hold aligner_ready_i = 1 -> A0..A3 are delivered in order on 4 consecutive cycles, and level_o returns to 0.
REQ-036 With level 2, assert flush_i together with in_valid_i = 1 -> the next cycle level_o = 0, fetch_valid_o = 0, and the pushed word is absent.
REQ-037 Push 32'h0000_0001 with parity_inject_i = 1, then pop -> perr_o = 1 during the pop cycle and perr_cnt_o = 1 afterwards; after 260 such pops perr_cnt_o = 8'hFF; perr_clr_i for 1 cycle -> perr_cnt_o = 0.
REQ-038 Drive continuous push and pop for 20 cycles from level 1 -> level_o stays at 1, data order is preserved across pointer wrap-around, and there are no drops.
REQ-039 Pull rst_n low asynchronously between clock edges with level 3 -> fetch_valid_o = 0 and level_o = 0 before the next edge, and in_ready_o = 1.
